// File: rtl/teclado_emulador.sv
// 4x4 matrix-keypad responder: closes one emulated key against the scanner's
// column strobes, with LFSR-driven contact bounce at press and release.
module teclado_emulador #(
    parameter int          BOUNCE_CYC = 16,
    parameter logic [7:0]  SEED       = 8'hA5,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:1]       colunas,
    output logic [4:1]       linhas,
    input  logic             req,
    input  logic [3:0]       key,
    input  logic [CNT_W-1:0] hold_len,
    output logic             busy,
    output logic             done,
    output logic [7:0]       press_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        B_PRESS = 2'd1,
        HOLD    = 2'd2,
        B_REL   = 2'd3
    } state_t;

    localparam logic [7:0]       SEED_EFF    = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam bit               BOUNCE_EN   = (BOUNCE_CYC > 0);
    localparam logic [CNT_W-1:0] BOUNCE_LAST = BOUNCE_EN ? CNT_W'(BOUNCE_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    // Fibonacci LFSR for x^8+x^6+x^5+x^4+1, shifting toward the MSB
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       key_q, key_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [7:0]       pc_q, pc_d;

    logic [CNT_W-1:0] hold_eff_s;
    logic             contact_s;
    logic [3:0]       col_s;
    logic [3:0]       lin_s;

    assign hold_eff_s = (hold_len == '0) ? CNT_ONE : hold_len;

    // Phase sequencing: next state, phase counter, latched request and completion bookkeeping
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        pc_d    = pc_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    key_d  = key;
                    hold_d = hold_eff_s;
                    if (BOUNCE_EN) begin
                        state_d = B_PRESS;
                        cnt_d   = BOUNCE_LAST;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = hold_eff_s - CNT_ONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            B_PRESS: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = hold_q - CNT_ONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    if (BOUNCE_EN) begin
                        state_d = B_REL;
                        cnt_d   = BOUNCE_LAST;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        pc_d    = pc_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            B_REL: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    pc_d    = pc_q + 8'd1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Bounce source: the LFSR only runs during the two bounce phases
    always_comb begin
        if ((state_q == B_PRESS) || (state_q == B_REL)) begin
            lfsr_d = lfsr_next(lfsr_q);
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // Contact closure as seen by the matrix, decoded from the registered phase
    always_comb begin
        case (state_q)
            IDLE:    contact_s = 1'b0;
            B_PRESS: contact_s = lfsr_q[0];
            HOLD:    contact_s = 1'b1;
            B_REL:   contact_s = lfsr_q[0];
            default: contact_s = 1'b0;
        endcase
    end

    assign col_s = colunas;

    // Switch path: zero-latency from the column strobes to the latched row
    always_comb begin
        lin_s = 4'b1111;
        if (contact_s && (col_s[key_q[1:0]] == 1'b0)) begin
            lin_s[key_q[3:2]] = 1'b0;
        end else begin
            lin_s = 4'b1111;
        end
    end

    assign linhas = lin_s;

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            key_q   <= 4'd0;
            hold_q  <= '0;
            lfsr_q  <= SEED_EFF;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pc_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            hold_q  <= hold_d;
            lfsr_q  <= lfsr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pc_q    <= pc_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign press_count = pc_q;

endmodule

// File: doc/teclado_emulador.md
Name: teclado_emulador

Overview:
Synthesizable 4x4 matrix-keypad responder: the far end of the keypad scan interface that controle_teclado drives.
- Watches the column strobes driven by a scanner and pulls the matching line low while an emulated key is closed.
- Emulates contact bounce, so the scanner and debounce logic can be exercised on-board without a physical keypad.
- Also serves as a remote setpoint-entry source, driven by a request/busy/done handshake.

Parameters:
BOUNCE_CYC, 16, clock cycles of emulated bounce at press and at release; 0 disables bounce
SEED, 8'hA5, LFSR reset value; must be nonzero (0 is replaced by 8'h01)
CNT_W, 16, width of hold_len and the internal phase counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
colunas  in  4 [4:1]  column strobes from the scanner; active-low, normally one-cold
linhas  out  4 [4:1]  line returns to the scanner; idle high, low when the pressed key connects to a low column
req  in  1  press request, sampled only in IDLE
key  in  4  key index: row = key[3:2]+1, column = key[1:0]+1
hold_len  in  CNT_W  stable-closed duration in cycles; 0 is treated as 1
busy  out  1  high from the cycle after acceptance until release completes
done  out  1  one-cycle pulse when a press/release sequence ends
press_count  out  8  completed-press counter, wraps 255->0

Behaviour:
- Reset (async assert, released on clk):
  - State = IDLE; contact = 0; linhas = 4'b1111; busy = 0; done = 0; press_count = 0; LFSR = SEED.
  - Latched key and hold_len are cleared.
- linhas (combinational from registered state and colunas):
  - linhas[r] = 0 iff contact = 1 AND r = latched row AND colunas[latched col] = 0.
  - Every other line is 1.
  - Zero-latency response to colunas, like a real switch.
  - Several columns low at once: the rule above still applies; no ghosting beyond it.
  - colunas = 4'b1111: linhas = 4'b1111.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Advances every cycle while in B_PRESS or B_REL; frozen otherwise.
- FSM states: IDLE, B_PRESS, HOLD, B_REL.
  - IDLE: contact = 0, busy = 0.
    - On req = 1: latch key, and latch max(hold_len, 1) into the counter.
    - Next state is B_PRESS, or HOLD if BOUNCE_CYC = 0.
    - The phase counter loads BOUNCE_CYC-1 for B_PRESS, or latched hold-1 for HOLD.
  - B_PRESS: contact = LFSR[0], busy = 1, lasts exactly BOUNCE_CYC cycles, then HOLD.
  - HOLD: contact = 1, busy = 1, lasts exactly latched-hold cycles, then B_REL (or the end step directly if BOUNCE_CYC = 0).
  - B_REL: contact = LFSR[0], busy = 1, lasts exactly BOUNCE_CYC cycles.
  - End step:
    - Return to IDLE with contact = 0.
    - done = 1 for that first IDLE cycle.
    - press_count increments on the same edge.
- Latency and length:
  - busy rises on the edge that samples req.
  - Busy length = 2*BOUNCE_CYC + max(hold_len, 1) cycles exactly.
- Handshake and corner cases:
  - req is ignored while busy. key and hold_len changes during busy have no effect.
  - req high in the done cycle is accepted (back-to-back presses allowed).
  - done and busy are never high together.
  - Reset mid-sequence: contact opens and linhas = 1111 immediately (async). No done pulse; press_count = 0.

Test Plan:
1. Reset, BOUNCE_CYC=0, colunas walks 1110,1101,1011,0111 -> linhas stays 1111; busy=0; done=0; press_count=0.
2. BOUNCE_CYC=0, req with key=4'b0110 (row 2, col 3), hold_len=10 -> busy high exactly 10 cycles. While colunas=1011, linhas=1101; for any other one-cold colunas, linhas=1111. Then done pulses 1 cycle and press_count=1.
3. BOUNCE_CYC=16, SEED=8'hA5, key=0, hold_len=100:
   - busy length is 132 cycles.
   - In HOLD, linhas[1] is low whenever colunas[1]=0.
   - In bounce phases, linhas[1] tracks the reference LFSR[0] sequence bit-for-bit.
4. hold_len=0 and BOUNCE_CYC=0 -> busy high 1 cycle; done 1 cycle later. A second req held high through done is accepted in that same cycle; press_count=2 after both.
5. Assert reset during HOLD (cycle 5 of 10) -> linhas=1111 before the next clk edge; busy=0; no done pulse; press_count=0.
6. Toggle req, key and hold_len while busy -> the sequence keeps its original key and timing; exactly one done pulse results.
